trigger_unit: RTL and testbench
===============================

# trigger_unit

Programmable trigger generator sitting directly upstream of the logic-analyzer capture core: it watches the same probed data bus and drives the capture core's trigger input. Fires when a masked value/edge condition has occurred a programmed number of times, and only once the capture memory reports primed. Holds its trigger asserted until disarmed, so the downstream stop logic sees a stable level.

## Interface
Parameters:
- DATA_WIDTH, 8, width of probed data bus (matches capture core)
- COUNT_WIDTH, 8, width of occurrence count and hit counter

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- i_data  input  DATA_WIDTH  probed signals (same bus fed to capture core)
- i_value  input  DATA_WIDTH  compare value
- i_mask  input  DATA_WIDTH  compare mask; bit=1 participates, bit=0 ignored
- i_edge_mode  input  2  0=level, 1=rising match, 2=falling match, 3=any masked change
- i_count  input  COUNT_WIDTH  occurrences required to fire; 0 treated as 1
- i_arm  input  1  level: 1=arm request, 0=disarm
- i_primed  input  1  capture memory primed flag from capture core
- o_trigger  output  1  trigger to capture core (level, held while FIRED)
- o_armed  output  1  high in ARMED state
- o_hits  output  COUNT_WIDTH  qualifying events counted since arm

## Operation
- Config (i_value, i_mask, i_edge_mode, i_count) latched on IDLE->WAIT_PRIMED; changes while armed ignored.
- match = ((i_data ^ value_l) & mask_l) == 0. Registers: match_d (previous match), data_d (previous i_data), updated every cycle.
- event: level: match; rising: match & !match_d; falling: !match & match_d; change: ((i_data ^ data_d) & mask_l) != 0.
- target = (count_l == 0) ? 1 : count_l.
- FSM states IDLE, WAIT_PRIMED, ARMED, FIRED:
  - IDLE: i_arm=1 -> latch config, clear hits, WAIT_PRIMED.
  - WAIT_PRIMED: i_arm=0 -> IDLE; else i_primed=1 -> ARMED.
  - ARMED: first cycle is history-load only (events ignored, prevents spurious edge at arm). Thereafter on event: if hits+1 == target -> hits<=target, FIRED; else hits<=hits+1. i_arm=0 -> IDLE (takes priority over event).
  - FIRED: o_trigger=1; i_arm=0 -> IDLE. No re-fire without passing through IDLE.
- i_primed dropping after ARMED is ignored.
- hits never exceeds target; no wrap.

## Timing
- Reset values: state IDLE, o_trigger 0, o_armed 0, o_hits 0, match_d 0, data_d 0, latched config 0.
- Reset asserted mid-operation: immediate return to IDLE, outputs to reset values; release resumes IDLE.
- All outputs registered. Qualifying sample at edge N -> o_trigger high after edge N+1 (1-cycle latency); capture core's delay stage compensates.
- i_arm rise at edge N with i_primed=1 -> WAIT_PRIMED after N, ARMED after N+1, first counted sample at edge N+3.
- i_arm low at edge N -> o_trigger/o_armed low after N, hits cleared on next arm.
- Simultaneous disarm and final event: disarm wins, no trigger.

## Configuration
- TRIGGER_EXT_EN: when defined, adds port i_ext_trigger (input, 1, asynchronous external trigger). It passes a 2-flop synchronizer plus rising-edge detect; a detected edge counts as a qualifying event in ARMED (ORed with the compare event, counted once per cycle). Adds 3 cycles latency from pin to event. When undefined, the port and logic are absent; only compare events exist.

## Test plan
- Level mode, mask=0xFF, value=0x5A, count=1, primed=1, arm; drive 0x5A at cycle 10 -> o_trigger high at cycle 11, o_hits=1, stays high until i_arm=0.
- Rising mode, mask=0x0F, value=0x03, count=3; i_data toggles 0x13/0x00 each cycle -> o_hits 1,2,3, o_trigger on third rising match; i_data held 0x03 from arm -> no event (history-load cycle).
- count=0, change mode, mask=0x80 -> first bit-7 toggle fires trigger; toggles on masked-out bits -> no trigger.
- Arm with i_primed=0 for 20 cycles while i_data matches -> o_armed=0, o_trigger=0; raise primed -> trigger follows per latency.
- Disarm on same cycle as final event -> o_trigger stays 0, IDLE; async reset asserted in FIRED -> o_trigger 0 immediately.
- With TRIGGER_EXT_EN: i_ext_trigger pulse, mask=0, count=2 -> two pulses required; trigger 3+1 cycles after second pulse edge.

Source files
------------

// File: rtl/trigger_unit.sv
// Masked value/edge trigger generator feeding the logic-analyzer capture core.
// Optional TRIGGER_EXT_EN adds a synchronized external trigger input.
module trigger_unit #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic [DATA_WIDTH-1:0]  i_value,
  input  logic [DATA_WIDTH-1:0]  i_mask,
  input  logic [1:0]             i_edge_mode,
  input  logic [COUNT_WIDTH-1:0] i_count,
  input  logic                   i_arm,
  input  logic                   i_primed,
`ifdef TRIGGER_EXT_EN
  input  logic                   i_ext_trigger,
`endif
  output logic                   o_trigger,
  output logic                   o_armed,
  output logic [COUNT_WIDTH-1:0] o_hits
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRIMED,
    ARMED,
    FIRED
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0]  value_l, mask_l, data_d;
  logic [1:0]             mode_l;
  logic [COUNT_WIDTH-1:0] count_l, hits, hits_inc, target;
  logic                   match, match_d, first_q;
  logic                   cmp_evt, evt;
  logic                   latch_cfg, inc_hits;

  assign match    = ((i_data ^ value_l) & mask_l) == '0;
  assign hits_inc = hits + COUNT_WIDTH'(1);
  assign target   = (count_l == '0) ? COUNT_WIDTH'(1) : count_l;
  assign o_hits   = hits;

  always_comb begin
    cmp_evt = 1'b0;
    unique case (mode_l)
      2'd0: cmp_evt = match;
      2'd1: cmp_evt = match & ~match_d;
      2'd2: cmp_evt = ~match & match_d;
      default: cmp_evt = ((i_data ^ data_d) & mask_l) != '0;
    endcase
  end

`ifdef TRIGGER_EXT_EN
  logic [2:0] ext_sync;
  logic       ext_evt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_sync <= '0;
      ext_evt  <= 1'b0;
    end else begin
      ext_sync <= {ext_sync[1:0], i_ext_trigger};
      ext_evt  <= ext_sync[1] & ~ext_sync[2];
    end
  end

  assign evt = cmp_evt | ext_evt;
`else
  assign evt = cmp_evt;
`endif

  // first ARMED cycle only loads edge history, so arming never fires an edge
  always_comb begin
    state_n   = state;
    latch_cfg = 1'b0;
    inc_hits  = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_arm) begin
          state_n   = WAIT_PRIMED;
          latch_cfg = 1'b1;
        end
      end
      WAIT_PRIMED: begin
        if (!i_arm)        state_n = IDLE;
        else if (i_primed) state_n = ARMED;
      end
      ARMED: begin
        if (!i_arm) begin
          state_n = IDLE;
        end else if (evt && !first_q) begin
          inc_hits = 1'b1;
          if (hits_inc == target) state_n = FIRED;
        end
      end
      FIRED: begin
        if (!i_arm) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      value_l   <= '0;
      mask_l    <= '0;
      mode_l    <= '0;
      count_l   <= '0;
      hits      <= '0;
      match_d   <= 1'b0;
      data_d    <= '0;
      first_q   <= 1'b0;
      o_trigger <= 1'b0;
      o_armed   <= 1'b0;
    end else begin
      state     <= state_n;
      match_d   <= match;
      data_d    <= i_data;
      first_q   <= (state != ARMED);
      o_trigger <= (state == FIRED) & i_arm;
      o_armed   <= (state_n == ARMED);
      if (latch_cfg) begin
        value_l <= i_value;
        mask_l  <= i_mask;
        mode_l  <= i_edge_mode;
        count_l <= i_count;
        hits    <= '0;
      end else if (inc_hits) begin
        hits    <= hits_inc;
      end
    end
  end

endmodule

// File: tb/tb_trigger_unit.sv
// Scoreboard bench for trigger_unit: per-cycle expected outputs queued
// with each stimulus and checked after the clock edge.
module tb_trigger_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data, value, mask, count, hits;
  logic [1:0] mode;
  logic       arm, primed, trig, armed;
  logic       ext = 1'b0;

  typedef struct packed {
    logic       trig;
    logic       armed;
    logic [7:0] hits;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  trigger_unit dut (
    .clk         (clk),
    .reset       (reset),
    .i_data      (data),
    .i_value     (value),
    .i_mask      (mask),
    .i_edge_mode (mode),
    .i_count     (count),
    .i_arm       (arm),
    .i_primed    (primed),
`ifdef TRIGGER_EXT_EN
    .i_ext_trigger(ext),
`endif
    .o_trigger   (trig),
    .o_armed     (armed),
    .o_hits      (hits)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [7:0] d,
                      input logic a, input logic p,
                      input logic et, input logic ea,
                      input logic [7:0] eh);
    exp_t e;
    data   = d;
    arm    = a;
    primed = p;
    exp_q.push_back('{trig: et, armed: ea, hits: eh});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".trig"},  {31'd0, trig},  {31'd0, e.trig});
      check({tag, ".armed"}, {31'd0, armed}, {31'd0, e.armed});
      check({tag, ".hits"},  {24'd0, hits},  {24'd0, e.hits});
    end
  endtask

  task automatic cfg(input logic [7:0] v, input logic [7:0] m,
                     input logic [1:0] md, input logic [7:0] c);
    value = v;
    mask  = m;
    mode  = md;
    count = c;
  endtask

  initial begin
    reset = 1'b0;
    cfg(8'h00, 8'h00, 2'd0, 8'd0);
    data = '0; arm = 1'b0; primed = 1'b1;
    #12;
    check("rst.trig",  {31'd0, trig},  32'd0);
    check("rst.armed", {31'd0, armed}, 32'd0);
    check("rst.hits",  {24'd0, hits},  32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // level, count 1
    cfg(8'h5A, 8'hFF, 2'd0, 8'd1);
    step("lvl0", 8'h00, 1, 1, 0, 0, 0);
    step("lvl1", 8'h00, 1, 1, 0, 1, 0);
    step("lvl2", 8'h00, 1, 1, 0, 1, 0);
    step("lvl3", 8'h00, 1, 1, 0, 1, 0);
    step("lvl4", 8'h5A, 1, 1, 0, 0, 1);
    step("lvl5", 8'h00, 1, 1, 1, 0, 1);
    step("lvl6", 8'h00, 1, 1, 1, 0, 1);
    step("lvl7", 8'h00, 0, 1, 0, 0, 1);
    step("lvl8", 8'h00, 0, 1, 0, 0, 1);

    // rising, count 3, held match first
    cfg(8'h03, 8'h0F, 2'd1, 8'd3);
    step("rise0", 8'h03, 1, 1, 0, 0, 0);
    step("rise1", 8'h03, 1, 1, 0, 1, 0);
    step("rise2", 8'h03, 1, 1, 0, 1, 0);
    step("rise3", 8'h03, 1, 1, 0, 1, 0);
    step("rise4", 8'h00, 1, 1, 0, 1, 0);
    step("rise5", 8'h13, 1, 1, 0, 1, 1);
    step("rise6", 8'h00, 1, 1, 0, 1, 1);
    step("rise7", 8'h13, 1, 1, 0, 1, 2);
    step("rise8", 8'h00, 1, 1, 0, 1, 2);
    step("rise9", 8'h13, 1, 1, 0, 0, 3);
    step("riseA", 8'h00, 1, 1, 1, 0, 3);
    step("riseB", 8'h13, 1, 1, 1, 0, 3);
    step("riseC", 8'h00, 0, 1, 0, 0, 3);

    // change mode, count 0 acts as 1
    cfg(8'h00, 8'h80, 2'd3, 8'd0);
    step("chg0", 8'h00, 1, 1, 0, 0, 0);
    step("chg1", 8'h00, 1, 1, 0, 1, 0);
    step("chg2", 8'h00, 1, 1, 0, 1, 0);
    step("chg3", 8'h01, 1, 1, 0, 1, 0);
    step("chg4", 8'h7F, 1, 1, 0, 1, 0);
    step("chg5", 8'h00, 1, 1, 0, 1, 0);
    step("chg6", 8'h80, 1, 1, 0, 0, 1);
    step("chg7", 8'h80, 1, 1, 1, 0, 1);
    step("chg8", 8'h80, 0, 1, 0, 0, 1);

    // not primed, then primed, then reset in FIRED
    cfg(8'h5A, 8'hFF, 2'd0, 8'd1);
    step("prm0", 8'h5A, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      step("prmw", 8'h5A, 1, 0, 0, 0, 0);
    step("prm1", 8'h5A, 1, 1, 0, 1, 0);
    step("prm2", 8'h5A, 1, 1, 0, 1, 0);
    step("prm3", 8'h5A, 1, 1, 0, 0, 1);
    step("prm4", 8'h5A, 1, 1, 1, 0, 1);
    step("prm5", 8'h5A, 1, 0, 1, 0, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst.trig", {31'd0, trig}, 32'd0);
    check("arst.hits", {24'd0, hits}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step("arst1", 8'h5A, 0, 1, 0, 0, 0);

    // disarm coincides with final event
    cfg(8'h5A, 8'hFF, 2'd0, 8'd2);
    step("dis0", 8'h00, 1, 1, 0, 0, 0);
    step("dis1", 8'h00, 1, 1, 0, 1, 0);
    step("dis2", 8'h00, 1, 1, 0, 1, 0);
    step("dis3", 8'h5A, 1, 1, 0, 1, 1);
    step("dis4", 8'h00, 1, 1, 0, 1, 1);
    step("dis5", 8'h5A, 0, 1, 0, 0, 1);
    step("dis6", 8'h5A, 0, 1, 0, 0, 1);

    check("queue.empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
